reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 init_done  output  1  high once the post-reset clear sweep has completed.
REQ-006 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0.
REQ-007 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1; higher priority.
REQ-008 raddr0 / raddr1  input  ADDR_W each  read addresses.
REQ-009 rdata0 / rdata1  output  DATA_W each  read data, combinational from address.
REQ-010 claim_vld / claim_addr  input  1 / ADDR_W  mark an entry as awaiting a pending write.
REQ-011 busy0 / busy1  output  1 each  busy bit of raddr0 / raddr1.

Function
REQ-012 The FSM SHALL have states CLEAR and READY; reset enters CLEAR.
- CLEAR: a counter sweeps entries 1..DEPTH-1, one per cycle, writing 0.
- After DEPTH-1 cycles the FSM enters READY and sets init_done=1 (DEPTH-1 cycles after rst_n deassertion).
REQ-013 In CLEAR, write ports, claims and bypass SHALL be ignored, and rdata0/rdata1 SHALL read 0.
REQ-014 In READY, a write on either port SHALL update the addressed entry at the clock edge.
REQ-015 When both ports write the same address in one cycle, wdata1 SHALL be stored.
REQ-016 Writes to address 0 SHALL be discarded; reading address 0 SHALL return 0 and busy=0.
REQ-017 Bypass SHALL apply when raddrN matches an enabled write address in the same cycle.
- Port 1 match: rdata returns wdata1.
- Else port 0 match: rdata returns wdata0.
- Else: rdata returns the stored value.
- Address 0 is exempt from bypass.
REQ-018 Busy bits:
- A claim SHALL set busy[claim_addr] at the edge.
- A write on either port SHALL clear busy[waddr].
- Claim and write to the same address in one cycle: busy SHALL end set (claim wins).
REQ-019 busyN SHALL reflect the stored bit combinationally; no bypass of same-cycle claims or clears.
REQ-020 Address arithmetic SHALL be unsigned ADDR_W bits; the sweep counter SHALL stop at DEPTH-1 and not wrap.

Reset
REQ-021 Asserting rst_n low SHALL immediately and asynchronously:
- force the FSM to CLEAR
- zero the sweep counter to 1
- clear all busy bits
- drive init_done=0
REQ-022 The storage array SHALL not be reset directly; it is zeroed only by the sweep.
REQ-023 Reset asserted mid-sweep or in READY SHALL restart the full sweep.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum
- the default DATA_W and ADDR_W constants
REQ-025 The bypass/read mux SHALL be one sub-module, rf_read_port, instantiated once per read port.
REQ-026 The array and busy vector SHALL live in reg_file_mp; the design SHALL be 120-400 RTL lines.

Verification
REQ-027 Reset release, default parameters: init_done rises after exactly 31 cycles; then every raddr reads 0 and busy=0.
REQ-028 READY, we0=1 waddr0=5 wdata0=0xAAAA5555, raddr0=5 in the same cycle: rdata0=0xAAAA5555 before the edge; stored value 0xAAAA5555 after.
REQ-029 Both ports write address 7 (port 0: 0x1, port 1: 0x2): rdata shows 0x2 during the cycle and address 7 holds 0x2 afterwards.
REQ-030 Scoreboard sequence:
- Claim address 3: busy0=1 for raddr0=3.
- Write address 3 alone: busy0=0.
- Claim and write address 3 in the same cycle: busy0 ends at 1.
REQ-031 Write 0xFFFFFFFF to address 0 and claim address 0: raddr0=0 reads 0 with busy0=0; drop rst_n at sweep count 10: init_done=0 and busy bits cleared immediately, and the sweep restarts with a full 31 cycles.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_mp_pkg;

  // Default register width and address width.
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Controller state: CLEAR sweeps the array to zero, READY serves traffic.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  // True when an enabled write targets the given (non-zero) read address.
  function automatic logic addr_hit(input logic en, input logic [RF_ADDR_W-1:0] waddr,
                                    input logic [RF_ADDR_W-1:0] raddr);
    return en && (waddr == raddr);
  endfunction

endpackage

// File: rtl/reg_file_mp_read_port.sv
// One read port: write-through bypass in front of the stored value.
// Port 1 bypass beats port 0 bypass; address 0 and the CLEAR phase read zero.
module rf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_ready,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_waddr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [DATA_W-1:0] i_stored,
  output logic [DATA_W-1:0] o_rdata
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_we0 && (i_waddr0 == i_raddr);
  assign w_hit1 = i_we1 && (i_waddr1 == i_raddr);

  // Read mux: zero when not ready or address 0, else newest data wins.
  always_comb begin
    o_rdata = {DATA_W{1'b0}};
    if (!i_ready || (i_raddr == {ADDR_W{1'b0}})) begin
      o_rdata = {DATA_W{1'b0}};
    end else if (w_hit1) begin
      o_rdata = i_wdata1;
    end else if (w_hit0) begin
      o_rdata = i_wdata0;
    end else begin
      o_rdata = i_stored;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with a post-reset zeroing sweep
// and a per-entry busy bit that marks entries awaiting a pending write.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              claim_vld,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy0,
  output logic              busy1
);

  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_init_done;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;

  logic              w_ready;
  logic              w_we0_eff;
  logic              w_we1_eff;
  logic              w_claim_eff;
  logic              w_we0_store;
  logic [DATA_W-1:0] w_stored0;
  logic [DATA_W-1:0] w_stored1;

  // Writes to entry 0 and all traffic during the sweep are dropped here.
  assign w_ready     = (r_state == ST_READY);
  assign w_we0_eff   = w_ready && we0 && (waddr0 != ZERO_ADDR);
  assign w_we1_eff   = w_ready && we1 && (waddr1 != ZERO_ADDR);
  assign w_claim_eff = w_ready && claim_vld && (claim_addr != ZERO_ADDR);
  // Port 1 owns the entry when both ports hit the same address.
  assign w_we0_store = w_we0_eff && !(w_we1_eff && (waddr1 == waddr0));

  // Next-state logic: step the sweep counter until the last entry is cleared.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = FIRST_ADDR;
      end
    endcase
  end

  // State, sweep counter and init flag; reset restarts the whole sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= FIRST_ADDR;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  // Busy update per entry: a claim wins over a same-cycle write clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_claim_eff && (claim_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((w_we0_eff && (waddr0 == ADDR_W'(i))) ||
                   (w_we1_eff && (waddr1 == ADDR_W'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Busy vector register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Storage: zeroed only by the sweep, written by the ports once ready.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_cnt] <= {DATA_W{1'b0}};
    end else begin
      if (w_we0_store) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_we1_eff) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  assign w_stored0 = r_mem[raddr0];
  assign w_stored1 = r_mem[raddr1];

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd0 (
    .i_ready  (w_ready),
    .i_raddr  (raddr0),
    .i_we0    (w_we0_eff),
    .i_waddr0 (waddr0),
    .i_wdata0 (wdata0),
    .i_we1    (w_we1_eff),
    .i_waddr1 (waddr1),
    .i_wdata1 (wdata1),
    .i_stored (w_stored0),
    .o_rdata  (rdata0)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .i_ready  (w_ready),
    .i_raddr  (raddr1),
    .i_we0    (w_we0_eff),
    .i_waddr0 (waddr0),
    .i_wdata0 (wdata0),
    .i_we1    (w_we1_eff),
    .i_waddr1 (waddr1),
    .i_wdata1 (wdata1),
    .i_stored (w_stored1),
    .o_rdata  (rdata1)
  );

  // Busy reflects stored bits only; entry 0 is never busy.
  assign busy0     = (raddr0 != ZERO_ADDR) && r_busy[raddr0];
  assign busy1     = (raddr1 != ZERO_ADDR) && r_busy[raddr1];
  assign init_done = r_init_done;

endmodule
